pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/stall/flush controller for the mini-MIPS pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush controller for the mini-MIPS pipeline: N-source forwarding,
// load-use interlock, watchdog-guarded multi-cycle EX op and branch flush.
// Optional stall counter enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 5,
  parameter int REG_AW     = 5,
  parameter int NSRC       = 3,
  parameter int MC_MAX_LAT = 32,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg1_read,
  input  logic                       reg2_read,
  input  logic [REG_AW-1:0]          reg1_addr,
  input  logic [REG_AW-1:0]          reg2_addr,
  input  logic [NSRC-1:0]            fwd_we,
  input  logic [NSRC*REG_AW-1:0]     fwd_addr,
  input  logic                       ex_load,
  input  logic                       mc_start,
  input  logic                       mc_done,
  input  logic                       branch_taken,
  output logic [$clog2(NSRC+1)-1:0]  reg1_select,
  output logic [$clog2(NSRC+1)-1:0]  reg2_select,
  output logic [STAGES:0]            stall,
  output logic [STAGES:0]            flush,
  output logic                       mc_busy,
  output logic                       mc_timeout,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int SEL_W = $clog2(NSRC + 1);
  localparam int WD_W  = (MC_MAX_LAT > 1) ? $clog2(MC_MAX_LAT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_LAT - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [SEL_W-1:0] sel1, sel2;
  logic            load_use;

  // Scan from the farthest source down so the nearest (lowest k) match wins.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic                   rd,
    input logic [REG_AW-1:0]      addr,
    input logic [NSRC-1:0]        we,
    input logic [NSRC*REG_AW-1:0] faddr
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (rd && addr != '0) begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        if (we[k] && faddr[k*REG_AW +: REG_AW] == addr) sel = SEL_W'(k + 1);
      end
    end
    return sel;
  endfunction

  assign sel1 = fwd_sel(reg1_read, reg1_addr, fwd_we, fwd_addr);
  assign sel2 = fwd_sel(reg2_read, reg2_addr, fwd_we, fwd_addr);

  assign load_use = ex_load && fwd_we[0] &&
                    ((reg1_read && reg1_addr != '0 && reg1_addr == fwd_addr[REG_AW-1:0]) ||
                     (reg2_read && reg2_addr != '0 && reg2_addr == fwd_addr[REG_AW-1:0]));

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wd_d        = '0;
    stall       = '0;
    flush       = '0;
    mc_busy     = 1'b0;
    mc_timeout  = 1'b0;
    reg1_select = '0;
    reg2_select = '0;
    if (!rst) begin
      reg1_select = sel1;
      reg2_select = sel2;
      unique case (state_q)
        ST_IDLE: begin
          if (load_use) begin
            stall[2:0] = '1;
            flush[2]   = 1'b1;
          end else begin
            flush[1] = branch_taken;
            if (mc_start) state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Holding EX covers ID too, so a taken branch waits for re-evaluation.
          mc_busy    = 1'b1;
          stall[3:0] = '1;
          flush[3]   = 1'b1;
          if (mc_done) begin
            state_d = ST_IDLE;
          end else if (wd_q == WD_LAST) begin
            mc_timeout = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall[0] && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver predicts each cycle's outputs
// from a behavioural model and queues them; a monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int STAGES     = 5;
  localparam int REG_AW     = 5;
  localparam int NSRC       = 3;
  localparam int MC_MAX_LAT = 8;
  localparam int CNT_W      = 6;
  localparam int SEL_W      = $clog2(NSRC + 1);
  localparam int SW         = STAGES + 1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   reg1_read, reg2_read;
  logic [REG_AW-1:0]      reg1_addr, reg2_addr;
  logic [NSRC-1:0]        fwd_we;
  logic [NSRC*REG_AW-1:0] fwd_addr;
  logic                   ex_load, mc_start, mc_done, branch_taken;
  logic [SEL_W-1:0]       reg1_select, reg2_select;
  logic [SW-1:0]          stall, flush;
  logic                   mc_busy, mc_timeout;
  logic [CNT_W-1:0]       stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .STAGES(STAGES), .REG_AW(REG_AW), .NSRC(NSRC),
    .MC_MAX_LAT(MC_MAX_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .reg1_read(reg1_read), .reg2_read(reg2_read),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .ex_load(ex_load), .mc_start(mc_start), .mc_done(mc_done),
    .branch_taken(branch_taken),
    .reg1_select(reg1_select), .reg2_select(reg2_select),
    .stall(stall), .flush(flush),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic                   rst, r1, r2, ld, start, done, br;
    logic [REG_AW-1:0]      a1, a2;
    logic [NSRC-1:0]        we;
    logic [NSRC*REG_AW-1:0] fa;
  } stim_t;

  typedef struct {
    logic [SEL_W-1:0] s1, s2;
    logic [SW-1:0]    stall, flush;
    logic             busy, tmo;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference state: whether an op is in flight and which busy cycle (1-based) this is.
  bit m_busy = 1'b0;
  int m_age  = 0;
  int m_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SEL_W-1:0] ref_sel(input logic rd, input logic [REG_AW-1:0] a,
                                               input logic [NSRC-1:0] we,
                                               input logic [NSRC*REG_AW-1:0] fa);
    if (!rd || a == 0) return '0;
    for (int k = 0; k < NSRC; k++)
      if (we[k] && fa[k*REG_AW +: REG_AW] == a) return SEL_W'(k + 1);
    return '0;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 0; s.r1 = 0; s.r2 = 0; s.ld = 0; s.start = 0; s.done = 0; s.br = 0;
    s.a1 = '0; s.a2 = '0; s.we = '0; s.fa = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 149) == 0);
    s.r1    = $urandom_range(0, 1);
    s.r2    = $urandom_range(0, 1);
    s.a1    = REG_AW'($urandom_range(0, 7));
    s.a2    = REG_AW'($urandom_range(0, 7));
    s.we    = NSRC'($urandom);
    for (int k = 0; k < NSRC; k++) s.fa[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
    s.ld    = ($urandom_range(0, 3) == 0);
    s.start = ($urandom_range(0, 5) == 0);
    s.done  = ($urandom_range(0, 5) == 0);
    s.br    = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst = s.rst; reg1_read = s.r1; reg2_read = s.r2; reg1_addr = s.a1; reg2_addr = s.a2;
    fwd_we = s.we; fwd_addr = s.fa; ex_load = s.ld; mc_start = s.start; mc_done = s.done;
    branch_taken = s.br;

    e.s1 = '0; e.s2 = '0; e.stall = '0; e.flush = '0; e.busy = 0; e.tmo = 0;
    e.cnt = PERF ? CNT_W'(m_cnt) : '0;
    lu = s.ld && s.we[0] &&
         ((s.r1 && s.a1 != 0 && s.a1 == s.fa[REG_AW-1:0]) ||
          (s.r2 && s.a2 != 0 && s.a2 == s.fa[REG_AW-1:0]));
    if (!s.rst) begin
      e.s1 = ref_sel(s.r1, s.a1, s.we, s.fa);
      e.s2 = ref_sel(s.r2, s.a2, s.we, s.fa);
      if (m_busy) begin
        e.busy  = 1;
        e.stall = SW'((1 << 4) - 1);
        e.flush = SW'(1 << 3);
        e.tmo   = !s.done && (m_age == MC_MAX_LAT);
      end else if (lu) begin
        e.stall = SW'((1 << 3) - 1);
        e.flush = SW'(1 << 2);
      end else if (s.br) begin
        e.flush = SW'(1 << 1);
      end
    end
    sb_q.push_back(e);

    if (s.rst) begin
      m_busy = 0; m_age = 0; m_cnt = 0;
    end else begin
      if (e.stall[0] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (m_busy) begin
        if (s.done || e.tmo) m_busy = 0;
        else m_age++;
      end else if (s.start && !lu) begin
        m_busy = 1; m_age = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("reg1_select", 64'(reg1_select), 64'(e.s1));
        check("reg2_select", 64'(reg2_select), 64'(e.s2));
        check("stall",       64'(stall),       64'(e.stall));
        check("flush",       64'(flush),       64'(e.flush));
        check("mc_busy",     64'(mc_busy),     64'(e.busy));
        check("mc_timeout",  64'(mc_timeout),  64'(e.tmo));
        check("stall_cnt",   64'(stall_cnt),   64'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    stim_t s;
    rst = 1; reg1_read = 0; reg2_read = 0; reg1_addr = '0; reg2_addr = '0;
    fwd_we = '0; fwd_addr = '0; ex_load = 0; mc_start = 0; mc_done = 0; branch_taken = 0;

    // Reset held with random inputs.
    repeat (2) begin s = rand_stim(); s.rst = 1; step(s); end

    // Forwarding: MEM and WB both match, nearer MEM wins; r0 never forwards.
    s = idle_stim(); s.r1 = 1; s.a1 = 5; s.we = 3'b110; s.fa = {5'd5, 5'd5, 5'd9};
    step(s);
    s.a1 = 0; step(s);

    // Load-use on rt, then the same with rt not read.
    s = idle_stim(); s.ld = 1; s.we = 3'b001; s.fa = {5'd0, 5'd0, 5'd7};
    s.r2 = 1; s.a2 = 7;
    step(s);
    s.r2 = 0; step(s);

    // Multi-cycle op completing: done 4 cycles after start.
    s = idle_stim(); s.rst = 1; step(s);
    s = idle_stim(); s.start = 1; step(s);
    s = idle_stim(); repeat (3) step(s);
    s.done = 1; step(s);
    s.done = 0; step(s);

    // Multi-cycle op timing out, with branches offered while busy.
    s = idle_stim(); s.start = 1; step(s);
    s = idle_stim(); s.br = 1; repeat (9) step(s);

    // Reset on the second busy cycle.
    s = idle_stim(); s.start = 1; step(s);
    s = idle_stim(); step(s);
    s.rst = 1; step(s);
    s.rst = 0; step(s);

    repeat (2000) step(rand_stim());

    @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
